// File: rtl/tc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tc_pkg                                                           |
// | Shared types and constants for the timer_counter peripheral.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Word offsets within the 16-byte window
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = be[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tc_regs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tc_regs                                                          |
// | CTRL/PRESET storage with byte-enable writes and the read mux.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tc_regs
    import tc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       byteen,
    input  logic             hw_en_clr,
    input  logic [CNT_W-1:0] count,
    output logic [31:0]      rdata,
    output logic             ctrl_en,
    output logic [1:0]       ctrl_mode,
    output logic             ctrl_im_nxt,
    output logic [CNT_W-1:0] preset,
    output logic             reg_wr
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic [31:0]       preset_ext;
    logic [31:0]       count_ext;
    logic [31:0]       preset_merged;
    logic              wr;
    logic              ctrl_wr;
    logic              preset_wr;

    assign wr        = sel & (|byteen);
    assign ctrl_wr   = wr & (addr == REG_CTRL);
    assign preset_wr = wr & (addr == REG_PRESET);
    assign reg_wr    = ctrl_wr | preset_wr;

    always_comb begin
        preset_ext                = '0;
        preset_ext[CNT_W-1:0]     = preset;
        count_ext                 = '0;
        count_ext[CNT_W-1:0]      = count;
    end

    assign preset_merged = byte_merge(preset_ext, wdata, byteen);

    // A bus write to CTRL byte 0 takes priority over the hardware EN clear
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_wr && byteen[0]) begin
            ctrl_d = wdata[CTRL_W-1:0];
        end else if (hw_en_clr) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q <= '0;
            preset <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            if (preset_wr) begin
                preset <= preset_merged[CNT_W-1:0];
            end
        end
    end

    assign ctrl_en     = ctrl_q[CTRL_EN];
    assign ctrl_mode   = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    assign ctrl_im_nxt = ctrl_d[CTRL_IM];

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                REG_CTRL:   rdata[CTRL_W-1:0] = ctrl_q;
                REG_PRESET: rdata             = preset_ext;
                REG_COUNT:  rdata             = count_ext;
                default:    rdata             = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_counter                                                    |
// | Down-counting timer with interrupt; MODE 1 auto-reload is only   |
// | built when TC_AUTO_RELOAD_EN is defined.                         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module timer_counter
    import tc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e        state;
    tc_state_e        state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] preset;
    logic             ctrl_en;
    logic [1:0]       ctrl_mode;
    logic             ctrl_im_nxt;
    logic             reg_wr;
    logic             reload_mode;
    logic             cnt_zero;
    logic             do_load;
    logic             do_dec;
    logic             pend_set;
    logic             pend_clr_hw;
    logic             hw_en_clr;
    logic             irq_pend;
    logic             irq_pend_nxt;

    tc_regs #(
        .CNT_W (CNT_W)
    ) u_regs (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .addr        (addr),
        .wdata       (wdata),
        .byteen      (byteen),
        .hw_en_clr   (hw_en_clr),
        .count       (count),
        .rdata       (rdata),
        .ctrl_en     (ctrl_en),
        .ctrl_mode   (ctrl_mode),
        .ctrl_im_nxt (ctrl_im_nxt),
        .preset      (preset),
        .reg_wr      (reg_wr)
    );

`ifdef TC_AUTO_RELOAD_EN
    assign reload_mode = (ctrl_mode == MODE_RELOAD);
`else
    // MODE is stored for readback only; every mode runs one-shot
    logic unused_mode;
    assign unused_mode = ^ctrl_mode;
    assign reload_mode = 1'b0;
`endif

    assign cnt_zero = (count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl_en) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CNT;
            ST_CNT: begin
                if (!ctrl_en)      state_nxt = ST_IDLE;
                else if (cnt_zero) state_nxt = ST_INT;
            end
            ST_INT:  state_nxt = reload_mode ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        do_load     = (state == ST_LOAD);
        do_dec      = (state == ST_CNT) && ctrl_en && !cnt_zero;
        pend_set    = (state == ST_CNT) && ctrl_en && cnt_zero;
        pend_clr_hw = (state == ST_INT) && reload_mode;
        hw_en_clr   = (state == ST_INT) && !reload_mode;
    end

    // Setting the pending flag wins over a same-edge clear by bus write
    always_comb begin
        irq_pend_nxt = irq_pend;
        if (pend_set) begin
            irq_pend_nxt = 1'b1;
        end else if (pend_clr_hw || reg_wr) begin
            irq_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= '0;
            irq_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (do_load) begin
                count <= preset;
            end else if (do_dec) begin
                count <= count - 1'b1;
            end
            irq_pend <= irq_pend_nxt;
            irq      <= irq_pend_nxt & ctrl_im_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_timer_counter                                                 |
// | Scenario-driven scoreboard bench for timer_counter.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_timer_counter;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    timer_counter #(
        .CNT_W (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        sel    = 1'b1;
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        sel    = 1'b0;
        byteen = 4'h0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        sel    = 1'b1;
        addr   = a;
        byteen = 4'h0;
        #1;
        d   = rdata;
        sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        reset = 1'b0;
        bus_write(A_PRESET, 32'hFFFF_FFFF, 4'hF);
        bus_write(A_CTRL, 32'h0000_000F, 4'hF);
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            sb.push_back('{name: $sformatf("reset_reg%0d", a), val: 32'h0});
            rd(2'(a), got);
            e = sb.pop_front();
            n_cmp++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        sb.push_back('{name: "reset_irq", val: 32'h0});
        e = sb.pop_front();
        n_cmp++;
        if (32'(irq) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] got;
        bus_write(A_PRESET, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'hF);
        for (int k = 1; k <= 9; k++) begin
            sb.push_back('{name: $sformatf("oneshot_irq_e%0d", k), val: 32'(k >= 6)});
            tick(1);
            e = sb.pop_front();
            n_cmp++;
            if (32'(irq) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
            end
        end
        sb.push_back('{name: "oneshot_ctrl_en_clr", val: 32'h8});
        sb.push_back('{name: "oneshot_count", val: 32'h0});
        rd(A_CTRL, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        rd(A_COUNT, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        sb.push_back('{name: "oneshot_ack_irq", val: 32'h0});
        bus_write(A_CTRL, 32'h0, 4'hF);
        e = sb.pop_front();
        n_cmp++;
        if (32'(irq) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
    endtask

    task automatic test_auto_reload();
`ifdef TC_AUTO_RELOAD_EN
        logic [31:0] got;
        logic [31:0] ph_cnt [5];
        ph_cnt = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        bus_write(A_PRESET, 32'd2, 4'hF);
        bus_write(A_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 16; k++) begin
            sb.push_back('{name: $sformatf("reload_irq_e%0d", k), val: 32'((k >= 5) && (k % 5 == 0))});
            if (k >= 2) sb.push_back('{name: $sformatf("reload_count_e%0d", k), val: ph_cnt[(k - 2) % 5]});
            tick(1);
            e = sb.pop_front();
            n_cmp++;
            if (32'(irq) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
            end
            if (k >= 2) begin
                rd(A_COUNT, got);
                e = sb.pop_front();
                n_cmp++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
            end
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
        tick(2);
`endif
    endtask

    task automatic test_byte_enables();
        logic [31:0] got;
        bus_write(A_PRESET, 32'h0, 4'hF);
        bus_write(A_PRESET, 32'hAABB_CCDD, 4'b0101);
        sb.push_back('{name: "byteen_preset", val: 32'h00BB_00DD});
        rd(A_PRESET, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        bus_write(A_PRESET, 32'h1122_3344, 4'b1010);
        sb.push_back('{name: "byteen_preset_hi", val: 32'h11BB_33DD});
        rd(A_PRESET, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        sb.push_back('{name: "rsvd_read", val: 32'h0});
        rd(A_RSVD, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        sb.push_back('{name: "rdata_unselected", val: 32'h0});
        addr = A_PRESET;
        sel  = 1'b0;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (rdata !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, rdata, e.val);
        end
    endtask

    task automatic test_mask_corners();
        logic [31:0] got;
        // Masked run with PRESET=0: irq must never rise
        bus_write(A_PRESET, 32'h0, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'hF);
        for (int k = 1; k <= 6; k++) begin
            sb.push_back('{name: $sformatf("masked_irq_e%0d", k), val: 32'h0});
            tick(1);
            e = sb.pop_front();
            n_cmp++;
            if (32'(irq) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
            end
        end
        // Restart; enable IM on the very edge that sets the pending flag
        bus_write(A_CTRL, 32'h1, 4'hF);
        tick(2);
        sb.push_back('{name: "setwins_irq", val: 32'h1});
        bus_write(A_CTRL, 32'h9, 4'hF);
        e = sb.pop_front();
        n_cmp++;
        if (32'(irq) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
        // INT cycle: written EN survives the hardware clear
        bus_write(A_CTRL, 32'h9, 4'hF);
        sb.push_back('{name: "int_write_wins", val: 32'h9});
        rd(A_CTRL, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
        tick(2);
        // EN cleared mid-count freezes COUNT
        bus_write(A_PRESET, 32'd10, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'hF);
        tick(5);
        bus_write(A_CTRL, 32'h8, 4'hF);
        tick(3);
        bus_write(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        sb.push_back('{name: "frozen_count", val: 32'd6});
        sb.push_back('{name: "frozen_irq", val: 32'h0});
        rd(A_COUNT, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        e = sb.pop_front();
        n_cmp++;
        if (32'(irq) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] got;
        bus_write(A_PRESET, 32'd10, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'hF);
        tick(5);
        sb.push_back('{name: "premid_count", val: 32'd7});
        rd(A_COUNT, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        sb.push_back('{name: "midrst_count", val: 32'h0});
        sb.push_back('{name: "midrst_ctrl", val: 32'h0});
        rd(A_COUNT, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        rd(A_CTRL, got);
        e = sb.pop_front();
        n_cmp++;
        if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        for (int k = 1; k <= 15; k++) begin
            sb.push_back('{name: $sformatf("midrst_irq_e%0d", k), val: 32'h0});
            tick(1);
            e = sb.pop_front();
            n_cmp++;
            if (32'(irq) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, irq, e.val);
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        sel    = 1'b0;
        addr   = 2'd0;
        wdata  = 32'h0;
        byteen = 4'h0;
        tick(1);
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_byte_enables();
        test_mask_corners();
        test_reset_mid_count();
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
